// File: rtl/ksa_swap_initiator_pkg.sv
// Shared types and constants for the RC4 key-scheduling (KSA) swap initiator.
//
// Contents:
//   byte_t           8-bit S-box element / index type
//   KEY_LEN_DEFAULT  default secret-key length in bytes
//   KEY_IDX_W        width of the key-byte index k (covers key lengths up to 32)
//   ksa_state_e      controller state encoding
//   next_key_idx()   k increment that wraps at the configured key length
//
// Build option: KSA_INIT_PHASE_EN selects whether the S-box identity fill is part of the
// pass. The StInit enumerator is always declared so the encoding is build-independent.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned KEY_LEN_DEFAULT = 3;
  localparam int unsigned KEY_IDX_W       = 5;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StReadSi,
    StWaitSi,
    StCalcJ,
    StSwapReq,
    StSwapWait,
    StNext,
    StDone
  } ksa_state_e;

  // Key index steps 0,1,..,key_len-1,0,.. so that k always equals i mod key_len.
  function automatic logic [KEY_IDX_W-1:0] next_key_idx(input logic [KEY_IDX_W-1:0] k,
                                                        input int unsigned           key_len);
    logic [KEY_IDX_W-1:0] last;
    last = KEY_IDX_W'(key_len - 1);
    return (k == last) ? '0 : k + 1'b1;
  endfunction

endpackage

// File: rtl/ksa_swap_initiator_if.sv
// Bus bundle between the KSA swap initiator and its S-memory / swap responder.
//
// Signals:
//   s_addr     S-memory address (initiator -> memory)
//   s_rdata    S-memory read data, valid one cycle after s_addr (memory -> initiator)
//   s_wren     S-memory write strobe, identity-fill phase only
//   s_wdata    S-memory write data
//   swap_flag  one-cycle swap request (initiator -> responder)
//   counter_i  swap operand index i, held until swap_done
//   counter_j  swap operand index j, held until swap_done
//   swap_done  one-cycle swap completion (responder -> initiator)
//
// Modports: master = initiator side, slave = memory / responder side.
interface ksa_swap_initiator_if;
  import rc4_pkg::*;

  byte_t s_addr;
  byte_t s_rdata;
  logic  s_wren;
  byte_t s_wdata;
  logic  swap_flag;
  byte_t counter_i;
  byte_t counter_j;
  logic  swap_done;

  modport master (
    output s_addr,
    input  s_rdata,
    output s_wren,
    output s_wdata,
    output swap_flag,
    output counter_i,
    output counter_j,
    input  swap_done
  );

  modport slave (
    input  s_addr,
    output s_rdata,
    input  s_wren,
    input  s_wdata,
    input  swap_flag,
    input  counter_i,
    input  counter_j,
    output swap_done
  );

endinterface

// File: rtl/ksa_swap_initiator_key_byte_sel.sv
// Combinational key-byte selector.
//
// Parameters:
//   KEY_LEN     key length in bytes (1..32)
// Ports:
//   key_i       packed secret key, key byte 0 in the most significant byte
//   k_i         key byte index
//   key_byte_o  selected key byte; zero when k_i is out of range
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic [8*KEY_LEN-1:0] key_i,
  input  logic [KEY_IDX_W-1:0] k_i,
  output byte_t                key_byte_o
);

  always_comb begin
    key_byte_o = '0;
    for (int n = 0; n < int'(KEY_LEN); n++) begin
      if (k_i == KEY_IDX_W'(n)) begin
        key_byte_o = key_i[8*(int'(KEY_LEN)-1-n) +: 8];
      end
    end
  end

endmodule

// File: rtl/ksa_swap_initiator.sv
// RC4 key-scheduling swap initiator.
//
// Walks i = 0..255 once per pass. For each i it reads S[i], forms
// j = j + S[i] + key[i mod KEY_LEN] (mod 256) and hands the pair (i, j) to an external swap
// responder, waiting as long as needed for its completion pulse.
//
// Build option KSA_INIT_PHASE_EN: when defined, each pass first fills S[n] = n for
// n = 0..255 (one write per cycle). When undefined, the fill is absent, s_wren is constant 0
// and S must be loaded externally before start.
//
// Parameters:
//   KEY_LEN   secret-key length in bytes (1..32)
// Ports:
//   clk       clock, all state changes on its rising edge
//   reset     synchronous active-high reset, dominates every other input
//   start     one-cycle pass request, honoured only while idle
//   key       secret key, key byte 0 in the most significant byte
//   busy      high from the cycle after an accepted start until the done cycle
//   done      one-cycle pulse at pass completion
//   bus       S-memory and swap-responder signals (master side)
module ksa_swap_initiator
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] key,
  output logic                 busy,
  output logic                 done,
  ksa_swap_initiator_if.master bus
);

  ksa_state_e           state_q, state_d;
  byte_t                i_q, i_d;
  byte_t                j_q, j_d;
  logic [KEY_IDX_W-1:0] k_q, k_d;
  byte_t                key_byte;
  logic                 i_last;

  key_byte_sel #(
    .KEY_LEN (KEY_LEN)
  ) u_key_byte_sel (
    .key_i      (key),
    .k_i        (k_q),
    .key_byte_o (key_byte)
  );

  assign i_last = (i_q == 8'hFF);

  // State and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef KSA_INIT_PHASE_EN
          state_d = StInit;
`else
          state_d = StReadSi;
`endif
        end
      end
`ifdef KSA_INIT_PHASE_EN
      // i doubles as the fill address; the last write is at 255.
      StInit:     if (i_last) state_d = StReadSi;
`endif
      StReadSi:   state_d = StWaitSi;
      StWaitSi:   state_d = StCalcJ;
      StCalcJ:    state_d = StSwapReq;
      StSwapReq:  state_d = StSwapWait;
      StSwapWait: if (bus.swap_done) state_d = StNext;
      // Stop at 255 instead of wrapping so a pass issues exactly 256 swaps.
      StNext:     state_d = i_last ? StDone : StReadSi;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Index datapath.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          i_d = '0;
          j_d = '0;
          k_d = '0;
        end
      end
`ifdef KSA_INIT_PHASE_EN
      // Wraps 255 -> 0, leaving i ready for the first read.
      StInit:  i_d = i_q + 8'd1;
`endif
      // s_rdata holds S[i]: the address has been stable since StReadSi.
      StCalcJ: j_d = j_q + bus.s_rdata + key_byte;
      StNext: begin
        if (!i_last) begin
          i_d = i_q + 8'd1;
          k_d = next_key_idx(k_q, KEY_LEN);
        end
      end
      default: ;
    endcase
  end

  // Outputs, decoded from the registered state.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    bus.s_addr    = '0;
    bus.s_wren    = 1'b0;
    bus.s_wdata   = '0;
    bus.swap_flag = 1'b0;
    bus.counter_i = '0;
    bus.counter_j = '0;
    unique case (state_q)
`ifdef KSA_INIT_PHASE_EN
      StInit: begin
        busy        = 1'b1;
        bus.s_addr  = i_q;
        bus.s_wren  = 1'b1;
        bus.s_wdata = i_q;
      end
`endif
      StReadSi, StWaitSi, StCalcJ: begin
        busy       = 1'b1;
        bus.s_addr = i_q;
      end
      StSwapReq: begin
        busy          = 1'b1;
        bus.swap_flag = 1'b1;
        bus.counter_i = i_q;
        bus.counter_j = j_q;
      end
      // i and j are frozen here, so the operands stay stable until swap_done.
      StSwapWait: begin
        busy          = 1'b1;
        bus.counter_i = i_q;
        bus.counter_j = j_q;
      end
      StNext: busy = 1'b1;
      StDone: done = 1'b1;
      default: ;
    endcase
  end

endmodule
